// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen : raster counters, active-area decode and delayed
//                    HDMI/DVI sync / data-enable for the text pixel pipeline
// Revision 1.0
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 4
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       enable,
  output logic       video_active,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit constants so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA_END   = 11'(H_ACTIVE);
  localparam logic [10:0] VA_END   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_STOP  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_STOP  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ACT   = (HSYNC_POL != 0);
  localparam logic        VS_ACT   = (VSYNC_POL != 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_params
    $error("video_timing_gen: totals must be <= 1024 and PIPE_DELAY within 0..15");
  end

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       va_q, va_d, hs_q, hs_d, vs_q, vs_d;
  logic       ls_q, ls_d, fs_q, fs_d;

  // Every registered output is decoded from the next counter values so all agree in one cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (enable) begin
      if ({1'b0, x_q} == H_LAST) begin
        x_d = '0;
        y_d = ({1'b0, y_q} == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    va_d = ({1'b0, x_d} < HA_END) && ({1'b0, y_d} < VA_END);
    hs_d = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_STOP)) ? HS_ACT : ~HS_ACT;
    vs_d = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_STOP)) ? VS_ACT : ~VS_ACT;
    ls_d = enable && (x_d == '0);
    fs_d = enable && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      va_q <= 1'b0;
      hs_q <= ~HS_ACT;
      vs_q <= ~VS_ACT;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (enable) begin
        x_q  <= x_d;
        y_q  <= y_d;
        va_q <= va_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
  end

  assign pixel_x      = x_q;
  assign pixel_y      = y_q;
  assign video_active = va_q;
  assign line_start   = ls_q;
  assign frame_start  = fs_q;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign de_o    = va_q;
  end else begin : g_delay
    // Stage k holds {hsync, vsync, de} from k+1 enabled cycles ago.
    logic [2:0] dly_q [PIPE_DELAY];

    always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < PIPE_DELAY; k++) dly_q[k] <= {~HS_ACT, ~VS_ACT, 1'b0};
      end else if (enable) begin
        dly_q[0] <= {hs_q, vs_q, va_q};
        for (int k = 1; k < PIPE_DELAY; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign {hsync_o, vsync_o, de_o} = dly_q[PIPE_DELAY-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// tb_video_timing_gen : default-mode instance plus two reduced-raster instances
//                       (delay 3 / positive syncs, delay 0) against a raster model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 2;

  logic clk_pixel = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk_pixel = ~clk_pixel;

  logic [9:0] d_x, d_y, s_x, s_y, z_x, z_y;
  logic d_va, d_ls, d_fs, d_hs, d_vs, d_de;
  logic s_va, s_ls, s_fs, s_hs, s_vs, s_de;
  logic z_va, z_ls, z_fs, z_hs, z_vs, z_de;

  video_timing_gen u_dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
    .video_active(d_va), .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls),
    .frame_start(d_fs), .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de)
  );

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIPE_DELAY(3)
  ) u_sml (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
    .video_active(s_va), .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls),
    .frame_start(s_fs), .hsync_o(s_hs), .vsync_o(s_vs), .de_o(s_de)
  );

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HSYNC_POL(0), .VSYNC_POL(0), .PIPE_DELAY(0)
  ) u_zero (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
    .video_active(z_va), .pixel_x(z_x), .pixel_y(z_y), .line_start(z_ls),
    .frame_start(z_fs), .hsync_o(z_hs), .vsync_o(z_vs), .de_o(z_de)
  );

  wire [25:0] obs_v [3];
  assign obs_v[0] = {d_x, d_y, d_va, d_ls, d_fs, d_hs, d_vs, d_de};
  assign obs_v[1] = {s_x, s_y, s_va, s_ls, s_fs, s_hs, s_vs, s_de};
  assign obs_v[2] = {z_x, z_y, z_va, z_ls, z_fs, z_hs, z_vs, z_de};

  // Reference raster description of each instance
  int P_HA [3] = '{640, SHA, SHA};
  int P_HF [3] = '{16,  SHF, SHF};
  int P_HS [3] = '{96,  SHS, SHS};
  int P_HB [3] = '{48,  SHB, SHB};
  int P_VA [3] = '{480, SVA, SVA};
  int P_VF [3] = '{10,  SVF, SVF};
  int P_VS [3] = '{2,   SVS, SVS};
  int P_VB [3] = '{33,  SVB, SVB};
  bit P_HP [3] = '{1'b0, 1'b1, 1'b0};
  bit P_VP [3] = '{1'b0, 1'b1, 1'b0};
  int P_D  [3] = '{4, 3, 0};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: raster position, pulses, and a history of {hsync, vsync, active}; entry 0 is current.
  int         m_x [3];
  int         m_y [3];
  logic       m_ls [3];
  logic       m_fs [3];
  logic [2:0] hist [3][16];

  function automatic int ht(int i); return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i]; endfunction
  function automatic int vt(int i); return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i]; endfunction

  function automatic int nx(int i);
    return (m_x[i] == ht(i) - 1) ? 0 : m_x[i] + 1;
  endfunction

  function automatic int ny(int i);
    if (m_x[i] != ht(i) - 1) return m_y[i];
    return (m_y[i] == vt(i) - 1) ? 0 : m_y[i] + 1;
  endfunction

  function automatic logic [2:0] sig(int i, int x, int y);
    bit h_on = (x >= P_HA[i] + P_HF[i]) && (x < P_HA[i] + P_HF[i] + P_HS[i]);
    bit v_on = (y >= P_VA[i] + P_VF[i]) && (y < P_VA[i] + P_VF[i] + P_VS[i]);
    bit act  = (x < P_HA[i]) && (y < P_VA[i]);
    return {h_on ? P_HP[i] : ~P_HP[i], v_on ? P_VP[i] : ~P_VP[i], act};
  endfunction

  function automatic logic [25:0] expv(int i);
    logic [2:0] d = hist[i][P_D[i]];
    return {10'(m_x[i]), 10'(m_y[i]), hist[i][0][0], m_ls[i], m_fs[i], d};
  endfunction

  function automatic logic [25:0] rstv(int i);
    return {20'd0, 3'b000, ~P_HP[i], ~P_VP[i], 1'b0};
  endfunction

  always @(posedge clk_pixel or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_x[i]  <= 0;
        m_y[i]  <= 0;
        m_ls[i] <= 1'b0;
        m_fs[i] <= 1'b0;
        for (int k = 0; k < 16; k++) hist[i][k] <= {~P_HP[i], ~P_VP[i], 1'b0};
      end else if (enable) begin
        m_x[i]     <= nx(i);
        m_y[i]     <= ny(i);
        m_ls[i]    <= (nx(i) == 0);
        m_fs[i]    <= (nx(i) == 0) && (ny(i) == 0);
        hist[i][0] <= sig(i, nx(i), ny(i));
        for (int k = 1; k < 16; k++) hist[i][k] <= hist[i][k-1];
      end else begin
        m_ls[i] <= 1'b0;
        m_fs[i] <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Leaves the bench 1ns after the last reset edge; the next edge is release cycle k=1.
  task automatic apply_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_v[i] !== rstv(i)) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got %h expected %h", i, obs_v[i], rstv(i));
      end
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if ({d_x, d_y, d_fs} !== {10'(k), 10'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL release_count k=%0d: x=%0d y=%0d fs=%b expected x=%0d y=0 fs=0",
                 k, d_x, d_y, d_fs, k);
      end
    end
  endtask

  task automatic test_horizontal();
    int first_fall = -1;
    apply_reset();
    for (int k = 1; k <= 808; k++) begin
      int j = k - 4;
      bit exp_va = ((k % 800) < 640) && ((k / 800) < 480);
      bit exp_de = (j >= 1) && ((j % 800) < 640);
      bit exp_hs = !((j >= 1) && ((j % 800) >= 656) && ((j % 800) < 752));
      tick();
      if (first_fall < 0 && d_hs === 1'b0) first_fall = k;
      n_checks++;
      if ({d_x, d_va, d_hs, d_de} !== {10'(k % 800), exp_va, exp_hs, exp_de}) begin
        n_fail++;
        $display("FAIL horiz k=%0d: x=%0d va=%b hs=%b de=%b expected x=%0d va=%b hs=%b de=%b",
                 k, d_x, d_va, d_hs, d_de, k % 800, exp_va, exp_hs, exp_de);
      end
    end
    n_checks++;
    if (first_fall != 660) begin
      n_fail++;
      $display("FAIL hsync_o_fall: first low at cycle %0d expected 660", first_fall);
    end
  endtask

  task automatic test_vertical_and_wrap();
    localparam int HT = SHA + SHF + SHS + SHB;
    localparam int VT = SVA + SVF + SVS + SVB;
    int fs_at [$];
    apply_reset();
    for (int k = 1; k <= 2 * HT * VT; k++) begin
      int x  = k % HT;
      int y  = (k / HT) % VT;
      int j  = k - 3;
      int jy = (j / HT) % VT;
      int jx = j % HT;
      bit z_hexp = !((x >= SHA + SHF) && (x < SHA + SHF + SHS));
      bit z_vexp = !((y >= SVA + SVF) && (y < SVA + SVF + SVS));
      bit z_dexp = (x < SHA) && (y < SVA);
      bit s_vexp = (j >= 1) && (jy >= SVA + SVF) && (jy < SVA + SVF + SVS);
      bit s_hexp = (j >= 1) && (jx >= SHA + SHF) && (jx < SHA + SHF + SHS);
      bit s_dexp = (j >= 1) && (jx < SHA) && (jy < SVA);
      tick();
      if (s_fs === 1'b1) fs_at.push_back(k);
      n_checks++;
      if ({s_x, s_y, s_ls, s_fs, s_va} !== {10'(x), 10'(y), x == 0, (x == 0) && (y == 0), z_dexp}) begin
        n_fail++;
        $display("FAIL small_raster k=%0d: x=%0d y=%0d ls=%b fs=%b va=%b expected x=%0d y=%0d",
                 k, s_x, s_y, s_ls, s_fs, s_va, x, y);
      end
      n_checks++;
      if ({s_hs, s_vs, s_de} !== {s_hexp, s_vexp, s_dexp}) begin
        n_fail++;
        $display("FAIL small_delayed k=%0d: hs=%b vs=%b de=%b expected %b %b %b",
                 k, s_hs, s_vs, s_de, s_hexp, s_vexp, s_dexp);
      end
      n_checks++;
      if ({z_hs, z_vs, z_de, z_va} !== {z_hexp, z_vexp, z_dexp, z_dexp}) begin
        n_fail++;
        $display("FAIL zero_delay k=%0d: hs=%b vs=%b de=%b va=%b expected %b %b %b %b",
                 k, z_hs, z_vs, z_de, z_va, z_hexp, z_vexp, z_dexp, z_dexp);
      end
    end
    n_checks++;
    if (fs_at.size() != 2 || fs_at[0] != HT * VT || fs_at[1] - fs_at[0] != HT * VT) begin
      n_fail++;
      $display("FAIL frame_period: %0d frame_start pulses, first at %0d, expected 2 pulses every %0d",
               fs_at.size(), (fs_at.size() > 0) ? fs_at[0] : -1, HT * VT);
    end
  endtask

  task automatic test_stall();
    int waited = 0;
    bit seen   = 1'b0;
    apply_reset();
    for (int k = 1; k <= 5 * 800 + 300; k++) tick();
    n_checks++;
    if ({d_x, d_y} !== {10'd300, 10'd5}) begin
      n_fail++;
      $display("FAIL stall_entry: x=%0d y=%0d expected x=300 y=5", d_x, d_y);
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      waited++;
      n_checks++;
      if ({d_x, d_y, d_de, d_hs, d_ls, d_fs} !== {10'd300, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: x=%0d y=%0d de=%b hs=%b ls=%b fs=%b expected 300 5 1 1 0 0",
                 k, d_x, d_y, d_de, d_hs, d_ls, d_fs);
      end
    end
    enable = 1'b1;
    tick();
    waited++;
    n_checks++;
    if (d_x !== 10'd301) begin
      n_fail++;
      $display("FAIL stall_resume: x=%0d expected 301", d_x);
    end
    while (!seen && waited < 1000) begin
      if (d_hs === 1'b0) seen = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
    n_checks++;
    if (!seen || waited != 370) begin
      n_fail++;
      $display("FAIL stall_hsync_shift: hsync_o fell after %0d cycles (seen=%b) expected 370", waited, seen);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v[i] !== expv(i)) begin
          n_fail++;
          $display("FAIL random c=%0d inst%0d: got %h expected %h", c, i, obs_v[i], expv(i));
        end
      end
      enable = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset_midline();
    enable = 1'b1;
    for (int c = 0; c < 150; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_v[i] !== rstv(i)) begin
        n_fail++;
        $display("FAIL async_reset inst%0d: got %h expected %h", i, obs_v[i], rstv(i));
      end
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v[i] !== expv(i)) begin
          n_fail++;
          $display("FAIL post_reset c=%0d inst%0d: got %h expected %h", c, i, obs_v[i], expv(i));
        end
      end
      enable = ($urandom_range(0, 4) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_stall();
    test_vertical_and_wrap();
    test_random();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the text-mode pixel pipeline. Default mode is 640x480@60, 800x525 total, on clk_pixel.
- Drives the renderer's timing inputs: video_active, pixel_x, pixel_y.
- Also produces HDMI/DVI sync and data-enable outputs. These are delayed by a programmable number of pixel clocks so they stay aligned with the renderer's registered RGB output.
- Sits between the pixel-clock domain reset logic and the text renderer / TMDS encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- PIPE_DELAY, 4, clk_pixel cycles of delay on hsync_o/vsync_o/de_o; legal range 0..15

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  advance counters when high; freeze raster when low
- video_active  out  1  pixel (pixel_x, pixel_y) is inside the visible area
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when pixel_x==0
- frame_start  out  1  one-cycle pulse when pixel_x==0 and pixel_y==0
- hsync_o  out  1  delayed horizontal sync, polarity HSYNC_POL
- vsync_o  out  1  delayed vertical sync, polarity VSYNC_POL
- de_o  out  1  delayed data enable (video_active delayed by PIPE_DELAY)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be ≤1024; elaboration fails otherwise.
- Reset (rst_n low, asynchronous):
  - pixel_x=0, pixel_y=0.
  - video_active=0, line_start=0, frame_start=0, de_o=0.
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
  - All delay-line stages are cleared to those same inactive values.
  - Release is taken on the first rising clk_pixel edge with rst_n high.
- Counting, on each rising edge with enable=1:
  - pixel_x increments; pixel_x==H_TOTAL-1 wraps to 0.
  - On that wrap, pixel_y increments; pixel_y==V_TOTAL-1 wraps to 0.
  - Counters never take values ≥ their total.
- All outputs are registered and mutually coherent in the same cycle:
  - video_active = (pixel_x<H_ACTIVE) && (pixel_y<V_ACTIVE).
  - Implement by decoding the next counter values, not the current ones.
- Undelayed sync, internal:
  - hsync is active when H_ACTIVE+H_FP ≤ pixel_x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync is active when V_ACTIVE+V_FP ≤ pixel_y < V_ACTIVE+V_FP+V_SYNC (default 490..491), for entire lines.
- Pulses:
  - line_start is high exactly in the cycle where pixel_x==0.
  - frame_start is high only when pixel_x==0 and pixel_y==0.
- First cycle after reset release (enable=1): counters move 0,0 → 1,0. frame_start is not asserted for the reset-state pixel 0,0. The first frame_start occurs at the first wrap to 0,0.
- Delay line:
  - hsync_o, vsync_o and de_o equal the internal hsync, vsync and video_active from PIPE_DELAY cycles earlier.
  - PIPE_DELAY=0 means they are identical to the undelayed signals in the same cycle.
  - The delay line shifts only when enable=1, keeping alignment with a frozen pipeline.
- enable=0: all counters, registered outputs and delay stages hold their values. line_start and frame_start are forced to 0 while enable is low. Resuming continues from the held position.
- Reset mid-frame: immediate return to reset values. Timing resumes from 0,0 with no partial sync pulse carried through the delay line.

Test Plan:
- Reset/release:
  - Assert rst_n=0 mid-line.
  - Required: outputs immediately show x=0, y=0, video_active=0, hsync_o=1, vsync_o=1, de_o=0 (defaults).
  - After release, pixel_x counts 1,2,3.
- Horizontal timing, line 0:
  - Internal hsync is low exactly for pixel_x 656..751 (96 cycles).
  - video_active is high for x 0..639 and low for 640..799.
  - hsync_o falls 4 cycles after pixel_x reaches 656.
- Vertical timing:
  - vsync_o is low for lines 490 and 491 only (1600 clk_pixel cycles, delayed 4).
  - video_active stays 0 on lines 480..524.
- Frame wrap:
  - At x=799, y=524 the next cycle gives x=0, y=0, frame_start=1 for one cycle and line_start=1.
  - Frame period is 420000 cycles.
- Enable stall:
  - Drop enable for 10 cycles at x=300, y=5.
  - Counters, de_o and hsync_o hold; no pulses.
  - After resume the next x is 301, and the delayed hsync_o edge lands 10 cycles later than in a no-stall run.
- PIPE_DELAY=0 build: hsync_o, vsync_o and de_o match the internal signals cycle-for-cycle across a full frame.
